// File: rtl/mult_op_sequencer_pkg.sv
// Shared types and constants for the multiplier operand sequencer.
// State encoding, operand/product widths and the default multiplier latency.
package mult_op_sequencer_pkg;

  localparam int OP_W        = 8;
  localparam int PROD_W      = 16;
  localparam int DEF_MUL_LAT = 10;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } op_pair_t;

  function automatic op_pair_t pack_ops(
    input logic [OP_W-1:0] a,
    input logic [OP_W-1:0] b
  );
    op_pair_t p;
    p.a = a;
    p.b = b;
    return p;
  endfunction

endpackage

// File: rtl/mult_op_sequencer_fifo.sv
// Operand-pair FIFO: DEPTH entries, synchronous push/pop, show-ahead head.
// A push is refused while full even when a pop lands in the same cycle.
module op_fifo
  import mult_op_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  op_pair_t din,
  output op_pair_t dout,
  output logic     full,
  output logic     empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  op_pair_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mult_op_sequencer.sv
// Feeds queued operand pairs to the sequential multiplier one job at a time
// and hands each captured product downstream over valid/ready.
module mult_op_sequencer
  import mult_op_sequencer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  output logic              mul_start,
  input  logic [PROD_W-1:0] mul_c,
  input  logic              mul_neg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_c,
  output logic              out_neg,
  output logic              busy,
  output logic [7:0]        done_cnt
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  op_pair_t      head;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = (state == S_IDLE) && !fifo_empty;
  assign busy     = (state != S_IDLE);

  op_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pack_ops(in_a, in_b)),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // mul_start is registered so the restart pulse covers exactly the START cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_start <= 1'b0;
      out_valid <= 1'b0;
      out_c     <= '0;
      out_neg   <= 1'b0;
      done_cnt  <= '0;
    end else begin
      mul_start <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            mul_a     <= head.a;
            mul_b     <= head.b;
            mul_start <= 1'b1;
            state     <= S_START;
          end
        end
        S_START: begin
          cnt   <= CW'(MUL_LAT - 1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == '0) begin
            out_c     <= mul_c;
            out_neg   <= mul_neg;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            done_cnt  <= done_cnt + 8'd1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_op_sequencer.sv
// Scoreboard bench for mult_op_sequencer with a behavioural multiplier model.
// Expected results are queued at push time and popped on each accepted result.
module tb_mult_op_sequencer;

  localparam int DEPTH   = 4;
  localparam int MUL_LAT = 10;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        mul_start;
  logic [15:0] mul_c;
  logic        mul_neg;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_c;
  logic        out_neg;
  logic        busy;
  logic [7:0]  done_cnt;

  typedef struct {
    logic [15:0] c;
    logic        neg;
  } exp_t;

  exp_t expq[$];
  int   starts[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   exp_done    = 0;
  int   mcnt        = 1000;
  logic prev_start  = 1'b0;

  mult_op_sequencer #(
    .DEPTH   (DEPTH),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_start (mul_start),
    .mul_c     (mul_c),
    .mul_neg   (mul_neg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .out_neg   (out_neg),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  function automatic logic [15:0] mul16(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = $signed(a) * $signed(b);
    return p[15:0];
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: product is only valid MUL_LAT cycles after restart ends
  always @(posedge clk) begin
    if (mul_start) mcnt <= 0;
    else if (mcnt < 1000) mcnt <= mcnt + 1;
  end
  assign mul_c   = (mcnt >= MUL_LAT - 1) ? mul16(mul_a, mul_b) : 16'hDEAD;
  assign mul_neg = (mcnt >= MUL_LAT - 1) ? (mul_a[7] ^ mul_b[7]) : 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: compare every accepted result against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst && mul_start) begin
        starts.push_back(cyc);
        check("start_pulse_width", 32'(prev_start), 32'd0);
      end
      prev_start = rst && mul_start;
      if (rst && out_valid && out_ready) begin
        check("result_expected", 32'(expq.size() != 0), 32'd1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          check("out_c", 32'(out_c), 32'(e.c));
          check("out_neg", 32'(out_neg), 32'(e.neg));
          check("done_cnt", 32'(done_cnt), 32'(exp_done));
          exp_done = (exp_done + 1) % 256;
        end
      end
    end
  end

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (in_ready) expq.push_back('{mul16(a, b), a[7] ^ b[7]});
    else check("push_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    #1;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || expq.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] snap_c;
    logic snap_n;
    logic seen;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outs", {out_valid, out_neg, busy, mul_start, in_ready},
          32'b00001);
    check("reset_data", {out_c, mul_a, mul_b}, 32'd0);
    check("reset_done_cnt", 32'(done_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // single job latency and contents
    starts.delete();
    push_pair(8'd2, 8'hFC);
    wait_out(n);
    check("latency", n, MUL_LAT + 2);
    check("single_c", 32'(out_c), 32'h0000FFF8);
    check("single_neg", 32'(out_neg), 32'd1);
    check("single_starts", starts.size(), 32'd1);
    @(negedge clk);
    #1;
    check("done_cnt_after_one", 32'(done_cnt), 32'd1);
    @(negedge clk);

    // three queued jobs, back-to-back starts
    starts.delete();
    push_pair(8'd2, 8'hFC);
    push_pair(8'd9, 8'hFD);
    push_pair(8'hF7, 8'd3);
    wait_idle();
    check("three_starts", starts.size(), 32'd3);
    if (starts.size() == 3) begin
      check("start_gap0", starts[1] - starts[0], MUL_LAT + 3);
      check("start_gap1", starts[2] - starts[1], MUL_LAT + 3);
    end

    // fill the FIFO while a job is in progress
    push_pair(8'd3, 8'd4);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      push_pair(8'($urandom), 8'($urandom));
      if (i == 3) check("full_in_ready", 32'(in_ready), 32'd0);
    end
    wait_idle();

    // backpressure in DONE
    out_ready = 1'b0;
    push_pair(8'd7, 8'hFE);
    push_pair(8'hFB, 8'hFA);
    wait_out(n);
    snap_c = out_c;
    snap_n = out_neg;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      check("stall_hold", {out_valid, out_neg, mul_start, out_c},
            {1'b1, snap_n, 1'b0, snap_c});
    end
    @(negedge clk);
    out_ready = 1'b1;
    n = 0;
    #1;
    while (!mul_start && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("restart_after_accept", n, 32'd2);
    @(negedge clk);
    wait_idle();

    // asynchronous reset in the middle of WAIT
    push_pair(8'd11, 8'd12);
    push_pair(8'd13, 8'd14);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset_outs", {out_valid, out_neg, busy, mul_start, in_ready},
          32'b00001);
    check("midreset_data", {out_c, mul_a, mul_b}, 32'd0);
    check("midreset_done_cnt", 32'(done_cnt), 32'd0);
    expq.delete();
    exp_done = 0;
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    check("post_reset_quiet", 32'(seen), 32'd0);

    // done_cnt wrap after 256 results
    for (int i = 0; i < 256; i++) push_pair(8'd1, 8'd1);
    wait_idle();
    check("done_cnt_wrap", 32'(done_cnt), 32'd0);

    // randomized traffic with random downstream backpressure
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          push_pair(8'($urandom), 8'($urandom));
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
      begin
        repeat (800) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(negedge clk);
    out_ready = 1'b1;
    wait_idle();
    check("random_done_cnt", 32'(done_cnt), 32'(exp_done));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_op_sequencer.md
Name: mult_op_sequencer

Overview:
Upstream feeder and result collector for the sequential signed 8x8 multiplier (`Multiplicador`). It buffers operand pairs arriving over a valid/ready handshake and issues one multiplication at a time. For each job it pulses the multiplier's restart input, holds the operands stable for a fixed latency, then captures the 16-bit product and sign flag and presents them downstream over a valid/ready handshake.

Parameters:
DEPTH, 4, operand FIFO entries (power of two, >=2)
MUL_LAT, 10, clock cycles from the end of the restart pulse until the multiplier's c/neg outputs are final (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
in_valid  input  1  operand pair offered
in_ready  output  1  FIFO can accept; equals !full
in_a  input  8  signed multiplicand
in_b  input  8  signed multiplier
mul_a  output  8  to Multiplicador A; registered
mul_b  output  8  to Multiplicador B; registered
mul_start  output  1  to Multiplicador rst; one-cycle high pulse per job
mul_c  input  16  from Multiplicador c
mul_neg  input  1  from Multiplicador neg
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out_c  output  16  captured signed product
out_neg  output  1  captured sign flag
busy  output  1  high in any state other than IDLE
done_cnt  output  8  completed-transfer counter; wraps 255->0

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO emptied; state=IDLE.
  - mul_a=0, mul_b=0, mul_start=0.
  - out_valid=0, out_c=0, out_neg=0, busy=0, done_cnt=0.
  - Asserting reset mid-job aborts the job. The popped operand pair and any FIFO contents are discarded. No result is produced.
- Input side:
  - A push occurs on an edge where in_valid && in_ready.
  - Full: in_ready=0. A push is refused even if a pop happens in the same cycle.
  - Push and pop in the same cycle when the FIFO is neither full nor empty: count is unchanged and both operations take effect.
  - Pointers wrap modulo DEPTH.
- FSM, states IDLE, START, WAIT, DONE:
  - IDLE: if FIFO is non-empty, pop the head, register it into mul_a/mul_b, and go to START. Otherwise stay.
  - START: mul_start=1 for exactly this cycle. Load cnt=MUL_LAT-1, then go to WAIT.
  - WAIT: mul_start=0. cnt decrements each cycle. When cnt==0, capture out_c<=mul_c and out_neg<=mul_neg, set out_valid, and go to DONE.
  - DONE: hold out_valid, out_c and out_neg until out_ready=1. On the accepting edge: clear out_valid, increment done_cnt, go to IDLE.
  - mul_a/mul_b are held constant from START through DONE. They change only on a pop.
- Latency:
  - A push into an empty FIFO while in IDLE at edge k gives out_valid=1 after edge k+2+MUL_LAT. With default MUL_LAT this is 12 cycles.
  - With out_ready tied high, back-to-back jobs start every MUL_LAT+3 cycles.
- Ordering: results emerge strictly in push order.
- Arithmetic: no arithmetic in this block. Product and sign pass through unmodified (two's complement, 16 bits).
- Stall: out_ready=0 indefinitely holds DONE. The FIFO keeps accepting pushes until full.

Decomposition:
- Shared package/include holds:
  - FSM state encoding (2-bit IDLE=0, START=1, WAIT=2, DONE=3).
  - Default MUL_LAT.
  - Operand width 8 and product width 16.
- One natural sub-module: op_fifo, a DEPTH x 16 synchronous FIFO with push/pop/full/empty and the same asynchronous active-low reset.
- The FSM and counter stay in mult_op_sequencer.

Test Plan:
- Bench uses the real Multiplicador or a model returning A*B after MUL_LAT cycles.
- Reset then single job: push (2,-4) -> mul_start one-cycle pulse; 12 cycles after push, out_valid=1, out_c=16'hFFF8, out_neg=1; done_cnt 0->1 on accept.
- Three queued jobs (2,-4), (9,-3), (-9,3), out_ready=1 -> results in order 16'hFFF8, 16'hFFE5, 16'hFFE5; each out_neg=1; starts spaced 13 cycles apart.
- Fill: push 5 pairs back-to-back while the first is in WAIT -> in_ready=0 after 4 stored; 5th accepted only after the next pop; no pair lost or duplicated.
- Backpressure: out_ready=0 for 20 cycles in DONE -> out_c/out_neg/out_valid stable; mul_start stays 0; on out_ready=1 the next job starts.
- Reset mid-WAIT: rst=0 for one cycle -> all outputs at reset values immediately; no out_valid afterwards without new pushes.
- done_cnt wrap: 256 accepted results (e.g. (1,1) -> 16'h0001, out_neg=0) -> done_cnt returns to 0.
